prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 23 ++
 rtl/word_packer.sv | 23 ++
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional trailing checksum byte is enabled with LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int MEMSIZE_DEFAULT = 768;
  localparam int WORD_BYTES      = 4;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_FLUSH,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Byte address of the word that contains byte offset cnt.
  function automatic logic [15:0] word_base(input logic [15:0] cnt);
    return cnt & ~16'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Collects stream bytes into one little-endian 32-bit word, lane by lane.
// Updates one cycle after load/clear; no backpressure, clear wins over load.
module word_packer (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  byte_dat,
  input  logic [1:0]  lane,
  input  logic        load,
  input  logic        clear,
  output logic [31:0] word
);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word[lane*8 +: 8] <= byte_dat;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream -> CPU word writes, CPU held in reset until done.
// One write per filled word; IN_READY registered and low outside length/data/checksum states. Macro: LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int MEMSIZE = MEMSIZE_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              write_flag,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_value,
  output logic              CPU_RESET,
  output logic              DONE,
  output logic              ERROR
);

  localparam logic [15:0] MEM_LEN = 16'(MEMSIZE);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CHK;
`else
  localparam state_t ST_AFTER = ST_DONE;
`endif

  state_t      state, state_d;
  logic        acc, last_byte;
  logic [1:0]  lane;
  logic [15:0] len, byte_cnt, len_full;
  logic        in_ready_d, wr_vld_d, pack_load;
  logic [31:0] wr_value_d, word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign acc       = IN_VALID && IN_READY;
  assign lane      = byte_cnt[1:0];
  assign last_byte = (byte_cnt + 16'd1) == len;
  assign len_full  = {IN_DATA, len[7:0]};

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= ST_LEN_LO;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_LEN_LO: if (acc) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (acc) begin
          if (len_full == 16'd0)        state_d = ST_AFTER;
          else if (len_full > MEM_LEN)  state_d = ST_ERR;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (acc && last_byte) state_d = (lane == 2'd3) ? ST_AFTER : ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_AFTER;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: if (acc) state_d = (IN_DATA == sum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_LEN_LO;
    endcase
  end

  // Ready follows the state we are entering so it lines up with the byte that state consumes.
  always_comb begin
    in_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                 (state_d == ST_DATA)   || (state_d == ST_CHK);
    wr_vld_d   = (state == ST_DATA && acc && lane == 2'd3) || (state == ST_FLUSH);
    wr_value_d = (state == ST_FLUSH) ? word : {IN_DATA, word[23:0]};
    pack_load  = (state == ST_DATA) && acc && (lane != 2'd3);
  end

  word_packer u_packer (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .byte_dat (IN_DATA),
    .lane     (lane),
    .load     (pack_load),
    .clear    (wr_vld_d),
    .word     (word)
  );

  // DONE/CPU_RESET follow the registered state, so CPU release lands after the final write pulse.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      IN_READY    <= 1'b0;
      write_flag  <= 1'b0;
      write_addr  <= '0;
      write_value <= '0;
      CPU_RESET   <= 1'b1;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      IN_READY   <= in_ready_d;
      write_flag <= wr_vld_d;
      if (wr_vld_d) begin
        write_addr  <= ADDR_W'(word_base(byte_cnt));
        write_value <= wr_value_d;
      end
      CPU_RESET <= (state != ST_DONE);
      DONE      <= (state == ST_DONE);
      ERROR     <= (state == ST_ERR);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      len      <= '0;
      byte_cnt <= '0;
    end else begin
      if (state == ST_LEN_LO && acc) len[7:0]  <= IN_DATA;
      if (state == ST_LEN_HI && acc) len[15:8] <= IN_DATA;
      if (state == ST_DATA && acc)   byte_cnt  <= byte_cnt + 16'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                    sum <= '0;
    else if (state == ST_DATA && acc) sum <= sum + IN_DATA;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: fixed and randomized streams against a queue-based model.
module tb_prog_loader;

  logic        CLOCK = 1'b0;
  logic        RESET, IN_VALID, IN_READY, write_flag, CPU_RESET, DONE, ERROR;
  logic [7:0]  IN_DATA;
  logic [31:0] write_addr, write_value;

  always #5 CLOCK = ~CLOCK;

  prog_loader dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .write_flag(write_flag), .write_addr(write_addr),
    .write_value(write_value), .CPU_RESET(CPU_RESET), .DONE(DONE), .ERROR(ERROR)
  );

  int          n_checks = 0, n_fail = 0;
  logic [7:0]  stim[$];
  logic [63:0] exp_w[$], obs_w[$];
  bit          exp_done, exp_err;
  int          cyc = 0, last_flag_cyc = -1, cpu_fall_cyc = -1, consec_err = 0;
  bit          prev_flag = 0, cpu_prev = 1;

  always @(negedge CLOCK) begin
    cyc++;
    if (write_flag === 1'b1) begin
      obs_w.push_back({write_addr, write_value});
      if (prev_flag) consec_err++;
      last_flag_cyc = cyc;
    end
    prev_flag = (write_flag === 1'b1);
    if (CPU_RESET === 1'b0 && cpu_prev) cpu_fall_cyc = cyc;
    cpu_prev = (CPU_RESET !== 1'b0);
  end

  task clear_obs();
    obs_w.delete();
    last_flag_cyc = -1;
    cpu_fall_cyc  = -1;
    consec_err    = 0;
  endtask

  task do_reset();
    @(negedge CLOCK);
    RESET = 1'b0;
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    clear_obs();
  endtask

  task append_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s;
    int len;
    s = 8'd0;
    len = stim[0] + 256 * stim[1];
    for (int i = 0; i < len; i++) s = s + stim[2+i];
    stim.push_back(s);
`endif
  endtask

  // Expected writes: payload chopped into 4-byte groups, zero padded, addressed by offset.
  task model();
    int len, s;
    logic [31:0] v;
    len = stim[0] + 256 * stim[1];
    exp_w.delete();
    exp_err = (len > 768);
    if (!exp_err) begin
      for (int b = 0; b < len; b += 4) begin
        v = 32'd0;
        for (int k = 0; k < 4; k++)
          if (b + k < len) v += 32'(stim[2+b+k]) << (8 * k);
        exp_w.push_back({32'(b), v});
      end
`ifdef LOADER_CHECKSUM_EN
      s = 0;
      for (int i = 0; i < len; i++) s += stim[2+i];
      if ((s % 256) != int'(stim[2+len])) exp_err = 1;
`else
      s = 0;
`endif
    end
    exp_done = !exp_err;
  endtask

  task send_bytes(input int from, input int to, input bit rnd);
    int tmo;
    for (int i = from; i < to; i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge CLOCK);
          IN_VALID = 1'b0;
          IN_DATA  = 8'($urandom);
        end
      end
      @(negedge CLOCK);
      IN_VALID = 1'b1;
      IN_DATA  = stim[i];
      tmo = 0;
      while (IN_READY !== 1'b1 && tmo < 100) begin
        @(negedge CLOCK);
        tmo++;
      end
      if (tmo >= 100) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: byte %0d IN_READY=%b required 1", i, IN_READY);
        IN_VALID = 1'b0;
        return;
      end
      @(posedge CLOCK);
    end
  endtask

  task wait_end();
    int t;
    t = 0;
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    while (!(DONE === 1'b1 || ERROR === 1'b1) && t < 60) begin
      @(negedge CLOCK);
      t++;
    end
    if (t >= 60) begin
      n_checks++; n_fail++;
      $display("FAIL end_timeout: DONE=%b ERROR=%b required one of them 1", DONE, ERROR);
    end
    repeat (3) @(negedge CLOCK);
  endtask

  task test_reset();
    RESET = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'd0;
    repeat (2) @(negedge CLOCK);
    n_checks++; if (IN_READY !== 1'b0)     begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", IN_READY); end
    n_checks++; if (write_flag !== 1'b0)   begin n_fail++; $display("FAIL rst_write_flag: got %b want 0", write_flag); end
    n_checks++; if (write_addr !== 32'd0)  begin n_fail++; $display("FAIL rst_write_addr: got %h want 0", write_addr); end
    n_checks++; if (write_value !== 32'd0) begin n_fail++; $display("FAIL rst_write_value: got %h want 0", write_value); end
    n_checks++; if (CPU_RESET !== 1'b1)    begin n_fail++; $display("FAIL rst_cpu_reset: got %b want 1", CPU_RESET); end
    n_checks++; if (DONE !== 1'b0)         begin n_fail++; $display("FAIL rst_done: got %b want 0", DONE); end
    n_checks++; if (ERROR !== 1'b0)        begin n_fail++; $display("FAIL rst_error: got %b want 0", ERROR); end
    RESET = 1'b1;
    @(negedge CLOCK);
    n_checks++; if (IN_READY !== 1'b1)     begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", IN_READY); end
    n_checks++; if (CPU_RESET !== 1'b1)    begin n_fail++; $display("FAIL post_rst_cpu_reset: got %b want 1", CPU_RESET); end
  endtask

  task test_fixed_streams();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      stim.delete();
      exp_w.delete();
      case (k)
        0: begin
          stim = '{8'h08, 8'h00, 8'hEB, 8'h00, 8'h55, 8'h89, 8'hE5, 8'h83, 8'hEC, 8'h10};
          exp_w = '{{32'd0, 32'h8955_00EB}, {32'd4, 32'h10EC_83E5}};
          exp_done = 1; exp_err = 0; append_chk();
        end
        1: begin
          stim = '{8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
          exp_w = '{{32'd0, 32'h4433_2211}, {32'd4, 32'h0000_0055}};
          exp_done = 1; exp_err = 0; append_chk();
        end
        2: begin
          stim = '{8'h01, 8'h04};
          exp_done = 0; exp_err = 1;
        end
        default: begin
          stim = '{8'h00, 8'h00};
          exp_done = 1; exp_err = 0; append_chk();
        end
      endcase
      send_bytes(0, stim.size(), 1'b0);
      wait_end();
      n_checks++;
      if (obs_w.size() != exp_w.size()) begin n_fail++; $display("FAIL fixed%0d_write_count: got %0d want %0d", k, obs_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL fixed%0d_write%0d: got addr/value %h want %h", k, i, obs_w[i], exp_w[i]); end
      end
      n_checks++; if (DONE !== exp_done)        begin n_fail++; $display("FAIL fixed%0d_done: got %b want %b", k, DONE, exp_done); end
      n_checks++; if (ERROR !== exp_err)        begin n_fail++; $display("FAIL fixed%0d_error: got %b want %b", k, ERROR, exp_err); end
      n_checks++; if (CPU_RESET !== !exp_done)  begin n_fail++; $display("FAIL fixed%0d_cpu_reset: got %b want %b", k, CPU_RESET, !exp_done); end
      n_checks++; if (IN_READY !== 1'b0)        begin n_fail++; $display("FAIL fixed%0d_in_ready: got %b want 0", k, IN_READY); end
      n_checks++; if (consec_err != 0)          begin n_fail++; $display("FAIL fixed%0d_flag_back_to_back: got %0d want 0", k, consec_err); end
      if (exp_done && exp_w.size() > 0) begin
        n_checks++;
        if (cpu_fall_cyc <= last_flag_cyc) begin n_fail++; $display("FAIL fixed%0d_cpu_release: fall cycle %0d last write cycle %0d", k, cpu_fall_cyc, last_flag_cyc); end
      end
    end
  endtask

  task test_random_loads();
    int len;
    for (int r = 0; r < 10; r++) begin
      len = (r == 0) ? 768 : (r == 1) ? 769 : (r == 2) ? 4 : int'($urandom_range(1, 40));
      stim.delete();
      stim.push_back(8'(len));
      stim.push_back(8'(len >> 8));
      if (len <= 768) begin
        for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
        append_chk();
      end
      model();
      do_reset();
      send_bytes(0, stim.size(), 1'b1);
      wait_end();
      n_checks++;
      if (obs_w.size() != exp_w.size()) begin n_fail++; $display("FAIL rand%0d_len%0d_write_count: got %0d want %0d", r, len, obs_w.size(), exp_w.size()); end
      for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
        n_checks++;
        if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL rand%0d_write%0d: got addr/value %h want %h", r, i, obs_w[i], exp_w[i]); end
      end
      n_checks++; if (DONE !== exp_done)       begin n_fail++; $display("FAIL rand%0d_done: got %b want %b", r, DONE, exp_done); end
      n_checks++; if (ERROR !== exp_err)       begin n_fail++; $display("FAIL rand%0d_error: got %b want %b", r, ERROR, exp_err); end
      n_checks++; if (CPU_RESET !== !exp_done) begin n_fail++; $display("FAIL rand%0d_cpu_reset: got %b want %b", r, CPU_RESET, !exp_done); end
      n_checks++; if (consec_err != 0)         begin n_fail++; $display("FAIL rand%0d_flag_back_to_back: got %0d want 0", r, consec_err); end
      if (exp_done && exp_w.size() > 0) begin
        n_checks++;
        if (cpu_fall_cyc <= last_flag_cyc) begin n_fail++; $display("FAIL rand%0d_cpu_release: fall cycle %0d last write cycle %0d", r, cpu_fall_cyc, last_flag_cyc); end
      end
    end
  endtask

  task test_ignore_after_done();
    int rdy_seen, n0;
    do_reset();
    stim = '{8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    append_chk();
    send_bytes(0, stim.size(), 1'b0);
    wait_end();
    n0 = obs_w.size();
    rdy_seen = 0;
    repeat (10) begin
      @(negedge CLOCK);
      IN_VALID = 1'b1;
      IN_DATA  = 8'($urandom);
      if (IN_READY !== 1'b0) rdy_seen++;
    end
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    n_checks++; if (rdy_seen != 0)       begin n_fail++; $display("FAIL done_ignore_ready: got %0d ready cycles want 0", rdy_seen); end
    n_checks++; if (obs_w.size() != 1)   begin n_fail++; $display("FAIL done_ignore_writes: got %0d want 1", obs_w.size()); end
    if (n0 > 0) begin
      n_checks++; if (obs_w[0] !== {32'd0, 32'hDDCC_BBAA}) begin n_fail++; $display("FAIL done_ignore_word: got %h want 00000000ddccbbaa", obs_w[0]); end
    end
    n_checks++; if (DONE !== 1'b1)       begin n_fail++; $display("FAIL done_ignore_done: got %b want 1", DONE); end
    n_checks++; if (CPU_RESET !== 1'b0)  begin n_fail++; $display("FAIL done_ignore_cpu_reset: got %b want 0", CPU_RESET); end
  endtask

  task test_reset_mid_load();
    do_reset();
    stim.delete();
    stim.push_back(8'd12);
    stim.push_back(8'd0);
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    append_chk();
    model();
    send_bytes(0, 8, 1'b1);
    @(negedge CLOCK);
    RESET = 1'b0;
    IN_VALID = 1'b0;
    #1;
    n_checks++; if (write_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_write_flag: got %b want 0", write_flag); end
    n_checks++; if (CPU_RESET !== 1'b1)  begin n_fail++; $display("FAIL midrst_cpu_reset: got %b want 1", CPU_RESET); end
    n_checks++; if (IN_READY !== 1'b0)   begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", IN_READY); end
    n_checks++; if (obs_w.size() != 1)   begin n_fail++; $display("FAIL midrst_writes_before: got %0d want 1", obs_w.size()); end
    if (obs_w.size() > 0) begin
      n_checks++; if (obs_w[0] !== exp_w[0]) begin n_fail++; $display("FAIL midrst_first_word: got %h want %h", obs_w[0], exp_w[0]); end
    end
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    repeat (20) @(negedge CLOCK);
    n_checks++; if (obs_w.size() != 1)   begin n_fail++; $display("FAIL midrst_writes_after: got %0d want 1", obs_w.size()); end
    n_checks++; if (CPU_RESET !== 1'b1)  begin n_fail++; $display("FAIL midrst_cpu_reset_after: got %b want 1", CPU_RESET); end
    n_checks++; if (IN_READY !== 1'b1)   begin n_fail++; $display("FAIL midrst_len_lo_ready: got %b want 1", IN_READY); end
    n_checks++; if (DONE !== 1'b0)       begin n_fail++; $display("FAIL midrst_done: got %b want 0", DONE); end
    // Fresh full load after the aborted one must start from the length prefix.
    clear_obs();
    send_bytes(0, stim.size(), 1'b1);
    wait_end();
    n_checks++; if (obs_w.size() != exp_w.size()) begin n_fail++; $display("FAIL reload_write_count: got %0d want %0d", obs_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      n_checks++;
      if (obs_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL reload_write%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
    end
    n_checks++; if (DONE !== 1'b1)       begin n_fail++; $display("FAIL reload_done: got %b want 1", DONE); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task test_checksum();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      stim = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
      if (k == 1) stim[4] = 8'h04;
      send_bytes(0, stim.size(), 1'b0);
      wait_end();
      n_checks++; if (obs_w.size() != 1) begin n_fail++; $display("FAIL chk%0d_write_count: got %0d want 1", k, obs_w.size()); end
      if (obs_w.size() > 0) begin
        n_checks++; if (obs_w[0] !== {32'd0, 32'h0000_0201}) begin n_fail++; $display("FAIL chk%0d_word: got %h want 0000000000000201", k, obs_w[0]); end
      end
      n_checks++; if (DONE !== (k == 0))      begin n_fail++; $display("FAIL chk%0d_done: got %b want %b", k, DONE, k == 0); end
      n_checks++; if (ERROR !== (k == 1))     begin n_fail++; $display("FAIL chk%0d_error: got %b want %b", k, ERROR, k == 1); end
      n_checks++; if (CPU_RESET !== (k == 1)) begin n_fail++; $display("FAIL chk%0d_cpu_reset: got %b want %b", k, CPU_RESET, k == 1); end
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_streams();
    test_random_loads();
    test_ignore_after_done();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
